// File: rtl/sent_tx_pulse_gen.sv
// ============================================================================
// Module      : sent_tx_pulse_gen
// Description : SENT (SAE J2716) transmit pulse encoder with CRC4 and a
//               one-deep pending frame buffer for back-to-back frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sent_tx_pulse_gen #(
    parameter int NIBBLES     = 6,
    parameter int LOW_TICKS   = 5,
    parameter int SYNC_TICKS  = 56,
    parameter int PAUSE_TICKS = 0,
    parameter int CNT_W       = 10
) (
    input  logic                   clk_tx,
    input  logic                   reset_tx,
    input  logic                   ticks,
    input  logic                   frame_valid,
    output logic                   frame_ready,
    input  logic [3:0]             status_in,
    input  logic [4*NIBBLES-1:0]   data_in,
    output logic                   sent_out,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int c_DW = 4 * NIBBLES;

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_SYNC   = 3'd1;
    localparam logic [2:0] c_S_STATUS = 3'd2;
    localparam logic [2:0] c_S_DATA   = 3'd3;
    localparam logic [2:0] c_S_CRC    = 3'd4;
    localparam logic [2:0] c_S_PAUSE  = 3'd5;
    localparam logic [2:0] c_S_END    = 3'd6;

    localparam logic [CNT_W-1:0] c_SYNC_LAST  = CNT_W'(SYNC_TICKS - 1);
    localparam logic [CNT_W-1:0] c_PAUSE_LAST = CNT_W'((PAUSE_TICKS > 0) ? PAUSE_TICKS - 1 : 0);
    localparam logic [CNT_W-1:0] c_LOW_LAST   = CNT_W'(LOW_TICKS - 1);
    localparam logic [CNT_W-1:0] c_LOW        = CNT_W'(LOW_TICKS);
    localparam logic [2:0]       c_NIB_LAST   = 3'(NIBBLES - 1);

    // CRC4 lookup table, entry i at bits [4*i +: 4]
    localparam logic [63:0] c_CRC_T = 64'h582F_B6C1_493E_A7D0;

    function automatic logic [3:0] crc_tab(input logic [3:0] idx);
        crc_tab = c_CRC_T[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] crc4(input logic [c_DW-1:0] d);
        logic [3:0] cs;
        cs = 4'b0101;
        for (int i = NIBBLES - 1; i >= 0; i--) begin
            cs = d[4*i +: 4] ^ crc_tab(cs);
        end
        crc4 = crc_tab(cs);
    endfunction

    logic              r_tick_q;
    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_out;
    logic              r_done;
    logic [2:0]        r_nib;
    logic              r_pend_full;
    logic [3:0]        r_pend_status;
    logic [c_DW-1:0]   r_pend_data;
    logic [3:0]        r_pend_crc;
    logic [3:0]        r_sh_status;
    logic [c_DW-1:0]   r_sh_data;
    logic [3:0]        r_sh_crc;

    logic              w_tick_en;
    logic              w_accept;
    logic [3:0]        w_crc;
    logic [3:0]        w_nib_cur;
    logic [4:0]        w_nib_last;
    logic [CNT_W-1:0]  w_last_cnt;
    logic [2:0]        w_state_nx;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic              w_out_nx;
    logic [2:0]        w_nib_nx;
    logic              w_load;
    logic              w_shift;
    logic              w_frame_end;

    assign w_tick_en   = ticks & ~r_tick_q;
    assign w_accept    = frame_valid & ~r_pend_full;
    assign w_crc       = crc4(data_in);

    assign frame_ready = ~r_pend_full;
    assign busy        = (r_state != c_S_IDLE);
    assign sent_out    = r_out;
    assign frame_done  = r_done;

    always_comb begin
        w_nib_cur = 4'h0;
        case (r_state)
            c_S_STATUS: w_nib_cur = r_sh_status;
            c_S_DATA:   w_nib_cur = r_sh_data[c_DW-1 -: 4];
            c_S_CRC:    w_nib_cur = r_sh_crc;
            default:    w_nib_cur = 4'h0;
        endcase
    end

    // Nibble pulses last 12+n ticks, so the final count is 11+n
    assign w_nib_last = {1'b0, w_nib_cur} + 5'd11;

    always_comb begin
        w_last_cnt = '0;
        case (r_state)
            c_S_SYNC:                     w_last_cnt = c_SYNC_LAST;
            c_S_STATUS, c_S_DATA, c_S_CRC: w_last_cnt = {{(CNT_W-5){1'b0}}, w_nib_last};
            c_S_PAUSE:                    w_last_cnt = c_PAUSE_LAST;
            c_S_END:                      w_last_cnt = c_LOW_LAST;
            default:                      w_last_cnt = '0;
        endcase
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_out_nx    = r_out;
        w_nib_nx    = r_nib;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_frame_end = 1'b0;
        if (w_tick_en) begin
            if (r_state == c_S_IDLE) begin
                if (r_pend_full) begin
                    w_load     = 1'b1;
                    w_state_nx = c_S_SYNC;
                    w_cnt_nx   = '0;
                    w_out_nx   = 1'b0;
                end
            end else if (r_cnt == w_last_cnt) begin
                w_cnt_nx = '0;
                w_out_nx = 1'b0;
                case (r_state)
                    c_S_SYNC:   w_state_nx = c_S_STATUS;
                    c_S_STATUS: begin
                        w_state_nx = c_S_DATA;
                        w_nib_nx   = 3'd0;
                    end
                    c_S_DATA: begin
                        w_shift  = 1'b1;
                        w_nib_nx = r_nib + 3'd1;
                        if (r_nib == c_NIB_LAST) begin
                            w_state_nx = c_S_CRC;
                        end
                    end
                    c_S_CRC: begin
                        if (PAUSE_TICKS != 0) begin
                            w_state_nx = c_S_PAUSE;
                        end else begin
                            w_frame_end = 1'b1;
                        end
                    end
                    c_S_PAUSE:  w_frame_end = 1'b1;
                    c_S_END: begin
                        w_state_nx = c_S_IDLE;
                        w_out_nx   = 1'b1;
                    end
                    default: begin
                        w_state_nx = c_S_IDLE;
                        w_out_nx   = 1'b1;
                    end
                endcase
                // The falling edge that closes a frame opens the next sync when one is waiting
                if (w_frame_end) begin
                    if (r_pend_full) begin
                        w_load     = 1'b1;
                        w_state_nx = c_S_SYNC;
                    end else begin
                        w_state_nx = c_S_END;
                    end
                end
            end else begin
                w_cnt_nx = r_cnt + 1'b1;
                if (w_cnt_nx == c_LOW) begin
                    w_out_nx = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_tx or negedge reset_tx) begin
        if (!reset_tx) begin
            r_tick_q      <= 1'b0;
            r_state       <= c_S_IDLE;
            r_cnt         <= '0;
            r_out         <= 1'b1;
            r_done        <= 1'b0;
            r_nib         <= 3'd0;
            r_pend_full   <= 1'b0;
            r_pend_status <= 4'h0;
            r_pend_data   <= '0;
            r_pend_crc    <= 4'h0;
            r_sh_status   <= 4'h0;
            r_sh_data     <= '0;
            r_sh_crc      <= 4'h0;
        end else begin
            r_tick_q <= ticks;
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_out    <= w_out_nx;
            r_nib    <= w_nib_nx;
            r_done   <= w_frame_end;

            if (w_load) begin
                r_sh_status <= r_pend_status;
                r_sh_data   <= r_pend_data;
                r_sh_crc    <= r_pend_crc;
            end else if (w_shift) begin
                r_sh_data   <= r_sh_data << 4;
            end

            if (w_accept) begin
                r_pend_full   <= 1'b1;
                r_pend_status <= status_in;
                r_pend_data   <= data_in;
                r_pend_crc    <= w_crc;
            end else if (w_load) begin
                r_pend_full   <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sent_tx_pulse_gen.sv
// ============================================================================
// Module      : tb_sent_tx_pulse_gen
// Description : Scoreboard bench for sent_tx_pulse_gen (two instances, with
//               and without a pause pulse).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sent_tx_pulse_gen;

    localparam int DIV    = 8;
    localparam int LOW    = 5;
    localparam int SYNC   = 56;
    localparam int PAUSE1 = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ticks;
    int          tdiv = 0;
    int          cyc  = 0;

    logic        valid [2];
    logic        ready [2];
    logic [3:0]  st    [2];
    logic [23:0] dat   [2];
    logic        sent  [2];
    logic        busy  [2];
    logic        done  [2];

    int          q0[$];
    int          q1[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_cnt [2];
    int          end_cnt  [2];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        tdiv <= (tdiv == DIV - 1) ? 0 : tdiv + 1;
    end
    assign ticks = (tdiv < DIV / 2);

    sent_tx_pulse_gen #(.NIBBLES(6), .LOW_TICKS(LOW), .SYNC_TICKS(SYNC),
                        .PAUSE_TICKS(0), .CNT_W(10)) dut0 (
        .clk_tx(clk), .reset_tx(rst_n), .ticks(ticks),
        .frame_valid(valid[0]), .frame_ready(ready[0]),
        .status_in(st[0]), .data_in(dat[0]),
        .sent_out(sent[0]), .busy(busy[0]), .frame_done(done[0])
    );

    sent_tx_pulse_gen #(.NIBBLES(6), .LOW_TICKS(LOW), .SYNC_TICKS(SYNC),
                        .PAUSE_TICKS(PAUSE1), .CNT_W(10)) dut1 (
        .clk_tx(clk), .reset_tx(rst_n), .ticks(ticks),
        .frame_valid(valid[1]), .frame_ready(ready[1]),
        .status_in(st[1]), .data_in(dat[1]),
        .sent_out(sent[1]), .busy(busy[1]), .frame_done(done[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic push_exp(input int k, input int v);
        if (k == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    function automatic int q_size(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int q_pop(input int k);
        if (k == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Expected pulse lengths in ticks; crc is the hand-computed CRC4
    task automatic push_frame(input int k, input logic [3:0] s, input logic [23:0] d,
                              input int crc);
        push_exp(k, SYNC);
        push_exp(k, 12 + int'(s));
        for (int i = 0; i < 6; i++) push_exp(k, 12 + int'(d[23-4*i -: 4]));
        push_exp(k, 12 + crc);
        if (k == 1) push_exp(k, PAUSE1);
    endtask

    task automatic send(input int k, input logic [3:0] s, input logic [23:0] d,
                        input int crc, input bit expect_full);
        int n;
        n = 0;
        @(negedge clk);
        valid[k] = 1'b1;
        st[k]    = s;
        dat[k]   = d;
        if (expect_full) chk("t6_ready_low", int'(ready[k]), 0);
        while (!ready[k] && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (!ready[k]) begin
            fail("send_timeout");
        end else begin
            @(posedge clk);
            push_frame(k, s, d, crc);
        end
        #1 valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        repeat (2 * DIV) @(negedge clk);
        while (busy[k] && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (busy[k]) fail("idle_timeout");
    endtask

    // Monitor: measures each pulse falling-edge to falling-edge and its low phase
    initial begin
        logic m_open [2];
        logic m_prev [2];
        logic m_pbusy[2];
        int   m_fall [2];
        int   m_rise [2];
        int   e;
        for (int k = 0; k < 2; k++) begin
            m_open[k] = 1'b0; m_prev[k] = 1'b1; m_pbusy[k] = 1'b0;
            m_fall[k] = 0;    m_rise[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    m_open[k]  = 1'b0;
                    m_prev[k]  = 1'b1;
                    m_pbusy[k] = 1'b0;
                end else begin
                    if (done[k]) done_cnt[k]++;
                    if (m_prev[k] && !sent[k]) begin
                        if (m_open[k]) begin
                            if (q_size(k) == 0) begin
                                fail("unexpected_pulse");
                            end else begin
                                e = q_pop(k);
                                chk("pulse_len", cyc - m_fall[k], e * DIV);
                                chk("pulse_low", m_rise[k] - m_fall[k], LOW * DIV);
                            end
                        end
                        m_open[k] = 1'b1;
                        m_fall[k] = cyc;
                    end
                    if (!m_prev[k] && sent[k]) m_rise[k] = cyc;
                    if (m_open[k] && m_pbusy[k] && !busy[k]) begin
                        chk("end_low", m_rise[k] - m_fall[k], LOW * DIV);
                        end_cnt[k]++;
                        m_open[k] = 1'b0;
                    end
                    m_prev[k]  = sent[k];
                    m_pbusy[k] = busy[k];
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            valid[k] = 1'b0; st[k] = 4'h0; dat[k] = 24'h0;
            done_cnt[k] = 0; end_cnt[k] = 0;
        end
        repeat (4) @(negedge clk);
        chk("rst_sent0",  int'(sent[0]),  1);
        chk("rst_ready0", int'(ready[0]), 1);
        chk("rst_busy0",  int'(busy[0]),  0);
        chk("rst_done0",  int'(done[0]),  0);
        chk("rst_sent1",  int'(sent[1]),  1);
        chk("rst_busy1",  int'(busy[1]),  0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_sent0", int'(sent[0]), 1);

        // Frame A, then B offered during A's data, then C offered while B waits
        send(0, 4'h0, 24'h000000, 5, 1'b0);
        repeat (80 * DIV) @(negedge clk);
        chk("a_busy", int'(busy[0]), 1);
        send(0, 4'h3, 24'h000001, 8, 1'b0);
        send(0, 4'h5, 24'h123456, 2, 1'b1);
        wait_idle(0);
        chk("abc_done_cnt", done_cnt[0], 3);
        chk("abc_end_cnt",  end_cnt[0],  1);
        chk("abc_q_empty",  q0.size(),   0);

        // Asynchronous reset in the middle of a data pulse
        send(0, 4'h5, 24'h123456, 2, 1'b0);
        repeat (80 * DIV) @(negedge clk);
        chk("t1_busy_before", int'(busy[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_sent",  int'(sent[0]),  1);
        chk("t1_busy",  int'(busy[0]),  0);
        chk("t1_ready", int'(ready[0]), 1);
        q0.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        chk("t1_idle_busy", int'(busy[0]), 0);
        chk("t1_idle_sent", int'(sent[0]), 1);
        chk("t1_done_cnt",  done_cnt[0],   3);

        // All-ones frame: longest nibble pulses
        send(0, 4'hF, 24'hFFFFFF, 10, 1'b0);
        wait_idle(0);
        chk("t3_done_cnt", done_cnt[0], 4);
        chk("t3_end_cnt",  end_cnt[0],  2);
        chk("t3_q_empty",  q0.size(),   0);

        // Pause-enabled instance
        send(1, 4'h0, 24'h000000, 5, 1'b0);
        wait_idle(1);
        chk("t5_done_cnt", done_cnt[1], 1);
        chk("t5_end_cnt",  end_cnt[1],  1);
        chk("t5_q_empty",  q1.size(),   0);
        chk("t5_sent_idle", int'(sent[1]), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
